// File: rtl/prog_enc_pkg.sv
// Shared definitions for the program encoder: mnemonics, machine opcodes, FSM states.
`default_nettype none

package prog_enc_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_LSL  = 4'd1,
        OP_LSR  = 4'd2,
        OP_NAND = 4'd3,
        OP_SUB  = 4'd4,
        OP_LDR  = 4'd5,
        OP_STR  = 4'd6,
        OP_ADDI = 4'd7,
        OP_BRZ  = 4'd8
    } mnemonic_e;

    // Opcode field values, bits [8:6] of the machine word, as seen by the control decoder.
    localparam logic [2:0] OPC_ADD  = 3'b000;
    localparam logic [2:0] OPC_LSL  = 3'b001;
    localparam logic [2:0] OPC_LSR  = 3'b010;
    localparam logic [2:0] OPC_NAND = 3'b011;
    localparam logic [2:0] OPC_SUB  = 3'b100;
    localparam logic [2:0] OPC_LDR  = 3'b101;
    localparam logic [2:0] OPC_STR  = 3'b110;
    localparam logic [2:0] OPC_EXT  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/prog_encoder_instr_pack.sv
// Combinational packer: symbolic instruction to 9-bit machine word plus illegal flag.
`default_nettype none

module instr_pack
    import prog_enc_pkg::*;
(
    input  logic [3:0] in_op,
    input  logic [2:0] in_a,
    input  logic [2:0] in_b,
    output logic [8:0] word,
    output logic       illegal
);

    always_comb begin
        word    = 9'd0;
        illegal = 1'b0;
        case (mnemonic_e'(in_op))
            OP_ADD:  word = {OPC_ADD,  in_a, in_b};
            OP_LSL:  word = {OPC_LSL,  in_a, in_b};
            OP_LSR:  word = {OPC_LSR,  in_a, in_b};
            OP_NAND: word = {OPC_NAND, in_a, in_b};
            OP_SUB:  word = {OPC_SUB,  in_a, in_b};
            OP_LDR:  word = {OPC_LDR,  in_a, in_b};
            OP_STR:  word = {OPC_STR,  in_a, in_b};
            // Bit 5 distinguishes ADDI (1) from BRZ (0) within the extended opcode.
            OP_ADDI: word = {OPC_EXT, 1'b1, in_a[1:0], in_b};
            OP_BRZ:  word = {OPC_EXT, 1'b0, in_a[1:0], in_b};
            default: illegal = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/prog_encoder.sv
// Streaming program loader: accepts symbolic instructions and writes packed words
// sequentially into instruction memory from address 0.
`default_nettype none

module prog_encoder
    import prog_enc_pkg::*;
#(
    parameter int AW    = 8,
    parameter int DEPTH = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_op,
    input  logic [2:0]    in_a,
    input  logic [2:0]    in_b,
    input  logic          in_last,
    output logic          im_we,
    output logic [AW-1:0] im_addr,
    output logic [8:0]    im_wdata,
    output logic [AW:0]   prog_len,
    output logic          done,
    output logic          err
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_e        state, state_next;
    logic [AW-1:0] addr;
    logic [8:0]    word;
    logic          illegal;
    logic          xfer;

    instr_pack u_pack (
        .in_op   (in_op),
        .in_a    (in_a),
        .in_b    (in_b),
        .word    (word),
        .illegal (illegal)
    );

    assign xfer = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        case (state)
            S_LOAD: begin
                in_ready = 1'b1;
                if (xfer) begin
                    if (illegal)                state_next = S_ERR;
                    else if (in_last)           state_next = S_DONE;
                    else if (addr == LAST_ADDR) state_next = S_ERR;
                end
            end
            S_DONE:  done = 1'b1;
            S_ERR:   err  = 1'b1;
            default: ;
        endcase
        // start wins over everything, including a same-cycle transfer.
        if (start) state_next = S_LOAD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr     <= '0;
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_wdata <= 9'd0;
            prog_len <= '0;
        end else begin
            im_we <= 1'b0;
            if (start) begin
                addr     <= '0;
                prog_len <= '0;
            end else if (xfer && !illegal) begin
                im_we    <= 1'b1;
                im_addr  <= addr;
                im_wdata <= word;
                addr     <= addr + 1'b1;
                prog_len <= prog_len + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_prog_encoder.sv
// Directed self-checking bench for prog_encoder (instantiated with DEPTH=4 to reach the full boundary).
`default_nettype none

module tb_prog_encoder;

    localparam int AW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_op;
    logic [2:0]    in_a;
    logic [2:0]    in_b;
    logic          in_last;
    logic          im_we;
    logic [AW-1:0] im_addr;
    logic [8:0]    im_wdata;
    logic [AW:0]   prog_len;
    logic          done;
    logic          err;

    int n_cmp = 0;
    int n_bad = 0;

    prog_encoder #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_op    (in_op),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_last  (in_last),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .prog_len (prog_len),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic [3:0] op, input logic [2:0] a, input logic [2:0] b,
                        input logic last);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++; if ({in_ready, im_we, done, err} !== 4'b0000) begin n_bad++;
            $display("FAIL reset_flags got=%b exp=0000", {in_ready, im_we, done, err}); end
        n_cmp++; if ({im_addr, im_wdata, prog_len} !== '0) begin n_bad++;
            $display("FAIL reset_data addr=%0h wdata=%0h len=%0d exp all 0", im_addr, im_wdata, prog_len); end
    endtask

    task automatic test_basic();
        pulse_start();
        n_cmp++; if (in_ready !== 1'b1 || done !== 1'b0) begin n_bad++;
            $display("FAIL basic_load ready=%b done=%b exp 1/0", in_ready, done); end
        send(4'd0, 3'd2, 3'd5, 1'b0);
        n_cmp++; if ({im_we, im_addr, im_wdata} !== {1'b1, 8'd0, 9'h015} || prog_len !== 9'd1) begin n_bad++;
            $display("FAIL basic_add we=%b addr=%0h wdata=%0h len=%0d exp 1/0/015/1", im_we, im_addr, im_wdata, prog_len); end
        send(4'd4, 3'd7, 3'd1, 1'b1);
        n_cmp++; if ({im_we, im_addr, im_wdata} !== {1'b1, 8'd1, 9'h139}) begin n_bad++;
            $display("FAIL basic_sub we=%b addr=%0h wdata=%0h exp 1/1/139", im_we, im_addr, im_wdata); end
        n_cmp++; if (done !== 1'b1 || prog_len !== 9'd2 || in_ready !== 1'b0) begin n_bad++;
            $display("FAIL basic_done done=%b len=%0d ready=%b exp 1/2/0", done, prog_len, in_ready); end
        step();
        n_cmp++; if (im_we !== 1'b0 || done !== 1'b1) begin n_bad++;
            $display("FAIL basic_pulse we=%b done=%b exp 0/1", im_we, done); end
    endtask

    task automatic test_ext_ops();
        pulse_start();
        send(4'd7, 3'd1, 3'd3, 1'b0);
        n_cmp++; if ({im_we, im_addr, im_wdata} !== {1'b1, 8'd0, 9'h1EB}) begin n_bad++;
            $display("FAIL ext_addi we=%b addr=%0h wdata=%0h exp 1/0/1eb", im_we, im_addr, im_wdata); end
        send(4'd8, 3'd2, 3'd4, 1'b0);
        n_cmp++; if ({im_we, im_addr, im_wdata} !== {1'b1, 8'd1, 9'h1D4}) begin n_bad++;
            $display("FAIL ext_brz we=%b addr=%0h wdata=%0h exp 1/1/1d4", im_we, im_addr, im_wdata); end
        send(4'd6, 3'd3, 3'd0, 1'b1);
        n_cmp++; if ({im_we, im_addr, im_wdata} !== {1'b1, 8'd2, 9'h198} || done !== 1'b1 || prog_len !== 9'd3) begin n_bad++;
            $display("FAIL ext_str we=%b addr=%0h wdata=%0h done=%b len=%0d exp 1/2/198/1/3",
                     im_we, im_addr, im_wdata, done, prog_len); end
    endtask

    task automatic test_illegal();
        pulse_start();
        send(4'd12, 3'd1, 3'd1, 1'b0);
        n_cmp++; if (im_we !== 1'b0 || err !== 1'b1 || in_ready !== 1'b0 || prog_len !== 9'd0) begin n_bad++;
            $display("FAIL illegal_op we=%b err=%b ready=%b len=%0d exp 0/1/0/0", im_we, err, in_ready, prog_len); end
        send(4'd0, 3'd1, 3'd1, 1'b0);
        n_cmp++; if (im_we !== 1'b0 || err !== 1'b1) begin n_bad++;
            $display("FAIL illegal_sticky we=%b err=%b exp 0/1", im_we, err); end
        pulse_start();
        n_cmp++; if (err !== 1'b0 || in_ready !== 1'b1) begin n_bad++;
            $display("FAIL illegal_clear err=%b ready=%b exp 0/1", err, in_ready); end
        send(4'd0, 3'd0, 3'd1, 1'b1);
        n_cmp++; if ({im_we, im_addr, im_wdata} !== {1'b1, 8'd0, 9'h001} || prog_len !== 9'd1) begin n_bad++;
            $display("FAIL illegal_restart we=%b addr=%0h wdata=%0h len=%0d exp 1/0/001/1", im_we, im_addr, im_wdata, prog_len); end
    endtask

    task automatic test_full();
        for (int pass = 0; pass < 2; pass++) begin
            pulse_start();
            for (int i = 0; i < DEPTH; i++) begin
                logic [8:0] exp_w;
                exp_w = {3'b001, 3'd1, 3'(i)};
                send(4'd1, 3'd1, 3'(i), (pass == 1) && (i == DEPTH - 1));
                n_cmp++; if ({im_we, im_addr, im_wdata} !== {1'b1, 8'(i), exp_w}) begin n_bad++;
                    $display("FAIL full_write pass=%0d i=%0d we=%b addr=%0h wdata=%0h exp 1/%0h/%0h",
                             pass, i, im_we, im_addr, im_wdata, i, exp_w); end
            end
            n_cmp++; if (prog_len !== 9'd4 || err !== (pass == 0) || done !== (pass == 1) || in_ready !== 1'b0) begin n_bad++;
                $display("FAIL full_end pass=%0d len=%0d err=%b done=%b ready=%b exp 4/%0d/%0d/0",
                         pass, prog_len, err, done, in_ready, pass == 0, pass == 1); end
            send(4'd0, 3'd0, 3'd0, 1'b0);
            n_cmp++; if (im_we !== 1'b0 || prog_len !== 9'd4) begin n_bad++;
                $display("FAIL full_nowrite pass=%0d we=%b len=%0d exp 0/4", pass, im_we, prog_len); end
        end
    endtask

    task automatic test_abort();
        pulse_start();
        send(4'd0, 3'd1, 3'd1, 1'b0);
        in_valid = 1'b1; in_op = 4'd2; in_a = 3'd5; in_b = 3'd5; start = 1'b1;
        step();
        start = 1'b0; in_valid = 1'b0;
        n_cmp++; if (im_we !== 1'b0 || prog_len !== 9'd0 || in_ready !== 1'b1) begin n_bad++;
            $display("FAIL abort_drop we=%b len=%0d ready=%b exp 0/0/1", im_we, prog_len, in_ready); end
        send(4'd3, 3'd1, 3'd2, 1'b1);
        n_cmp++; if ({im_we, im_addr, im_wdata} !== {1'b1, 8'd0, 9'h0CA} || prog_len !== 9'd1) begin n_bad++;
            $display("FAIL abort_restart we=%b addr=%0h wdata=%0h len=%0d exp 1/0/0ca/1", im_we, im_addr, im_wdata, prog_len); end
    endtask

    task automatic test_reset_midload();
        pulse_start();
        for (int i = 0; i < 3; i++) send(4'd5, 3'(i), 3'd7, 1'b0);
        n_cmp++; if (prog_len !== 9'd3 || im_we !== 1'b1) begin n_bad++;
            $display("FAIL midload_pre len=%0d we=%b exp 3/1", prog_len, im_we); end
        in_valid = 1'b1; in_op = 4'd0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({in_ready, im_we, done, err} !== 4'b0000 || {im_addr, im_wdata, prog_len} !== '0) begin n_bad++;
            $display("FAIL midload_reset ready=%b we=%b done=%b err=%b addr=%0h wdata=%0h len=%0d exp all 0",
                     in_ready, im_we, done, err, im_addr, im_wdata, prog_len); end
        step();
        n_cmp++; if (im_we !== 1'b0 || prog_len !== 9'd0) begin n_bad++;
            $display("FAIL midload_hold we=%b len=%0d exp 0/0", im_we, prog_len); end
        in_valid = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
        in_op = 4'd0; in_a = 3'd0; in_b = 3'd0; in_last = 1'b0;
        step();
        test_reset();
        rst_n = 1'b1;
        step();
        test_basic();
        test_ext_ops();
        test_illegal();
        test_full();
        test_abort();
        test_reset_midload();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/prog_encoder.md
Name: prog_encoder

Overview:
- Streaming machine-code encoder, the write side of the 9-bit instruction format consumed by the control decoder.
- Accepts symbolic instructions (mnemonic plus fields) over a valid/ready handshake.
- Packs each into a 9-bit word and writes it sequentially into instruction memory from address 0.
- Sits between the testbench/loader port and the instruction-memory write port. Used to load programs before the core is released from Start.

Parameters:
- AW, 8, instruction-memory address width.
- DEPTH, 256, number of writable words; must be ≤ 2**AW.

Ports:
- Clk  input  1  system clock.
- Reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a new program load at address 0.
- in_valid  input  1  symbolic instruction present.
- in_ready  output  1  encoder can accept this cycle.
- in_op  input  4  mnemonic, values in the package enum.
- in_a  input  3  first register field / addi register (low 2 bits) / branch how_high (low 2 bits).
- in_b  input  3  second register field / addi immediate / branch target index.
- in_last  input  1  marks the final instruction of the program.
- im_we  output  1  instruction-memory write strobe.
- im_addr  output  AW  write address.
- im_wdata  output  9  encoded machine word.
- prog_len  output  AW+1  number of words written in this load.
- done  output  1  load finished (level, held until next start).
- err  output  1  sticky: illegal mnemonic or overflow.

Behaviour:
- Encoding, bits [8:6] = opcode:
  - ADD=000, LSL=001, LSR=010, NAND=011, SUB=100, LDR=101, STR=110: word = {opc, in_a, in_b}.
  - ADDI: {111, 1, in_a[1:0], in_b}.
  - BRZ: {111, 0, in_a[1:0], in_b}. in_a[1:0] becomes how_high in bits [4:3].
- Reset: state=IDLE; in_ready=0, im_we=0, im_addr=0, im_wdata=0, prog_len=0, done=0, err=0.
- States:
  - IDLE: in_ready=0. On start → LOAD, with addr=0, prog_len=0, done=0, err=0.
  - LOAD: in_ready=1. A transfer occurs when in_valid&&in_ready.
    - One cycle after the transfer: im_we=1, im_addr=addr, im_wdata=encoded word.
    - addr and prog_len increment in that same cycle. im_we is a single-cycle pulse per word.
    - Transfer with in_last=1 → DONE after the write.
  - DONE: done=1, in_ready=0. Stays until start → LOAD (restarts from addr 0).
  - ERR: err=1, in_ready=0, no writes. Only start clears it (→ LOAD).
- Illegal in_op (enum values 9..15): the word is not written, prog_len is unchanged, → ERR.
- Full: the transfer that writes address DEPTH-1 without in_last → ERR after that write.
  - That word is written. prog_len=DEPTH.
  - Writing address DEPTH-1 with in_last → DONE, no error.
- start while in LOAD: aborts the load.
  - Any same-cycle transfer is dropped and no write is pending.
  - Restarts at addr 0 and clears prog_len/err.
- in_valid outside LOAD is ignored. There is no back-pressure beyond in_ready=0 in non-LOAD states.
- Throughput: one instruction per cycle in LOAD. Latency from transfer to im_we is 1 cycle.
- Reset mid-load: all state is cleared immediately (asynchronous); no partial write is issued.

Decomposition:
- Package prog_enc_pkg:
  - mnemonic enum (ADD..BRZ = 0..8).
  - 3-bit opcode constants shared with the control decoder.
  - state enum {IDLE, LOAD, DONE, ERR}.
- One combinational sub-module, instr_pack: in_op/in_a/in_b → 9-bit word plus illegal flag.
- Top holds the FSM, address counter and output registers.

Test Plan:
- Reset low mid-LOAD after 3 words → all outputs at reset values; prog_len=0, im_we=0.
- start; ADD a=2 b=5; SUB a=7 b=1 last → writes 0x015 @0 and 0x139 @1, each 1 cycle after transfer; done=1, prog_len=2.
- start; ADDI a=1 b=3; BRZ a=2 b=4; STR a=3 b=0 last → 0x1EB @0, 0x1D4 @1, 0x198 @2; done=1.
- start; in_op=12 → no im_we, err=1, in_ready=0; next start → err=0, addr 0.
- DEPTH=4: four words with no last → 4 writes, then err=1, prog_len=4. Repeat with last on the 4th word → done=1, err=0.
- start during LOAD with in_valid=1 → no write for that beat; next accepted word lands @0, prog_len=1.
